pu_result_collector: RTL

- Consumer end of the Pu1 processing-unit output interface.
- Tracks the PU's fixed pipeline latency by delaying the upstream issue strobes, then accumulates the 12-bit PU partial sums over a variable number of groups per output.
- Shifts and saturates each finished result and queues it in a small FIFO.
- Exposes results on a valid/ready port and returns a credit signal (issue_ready) to the operand issuer, because the PU itself cannot stall.

---
 rtl/pu_result_collector.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pu_result_collector.sv
// pu_result_collector
// Consumer end of the Pu1 output interface. A delay line re-aligns the issue
// strobes with pu_out, an unsigned saturating accumulator sums partial results
// over a variable number of groups, and each finished result is shifted,
// saturated and queued in a small first-word-fall-through FIFO. Because Pu1
// cannot stall, a credit signal (issue_ready) tells the issuer when another
// output-closing group may be launched without overrunning the FIFO.

module pu_result_collector #(
    parameter int PU_LATENCY = 2,
    parameter int IN_W       = 12,
    parameter int ACC_W      = 16,
    parameter int SHIFT      = 4,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             issue_last,
    input  logic [IN_W-1:0]  pu_out,
    output logic             issue_ready,
    output logic [OUT_W-1:0] res_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             overflow
);

    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int OUTS_W    = $clog2(FIFO_DEPTH + PU_LATENCY + 1);

    // ------------------------------------------------------------------
    // Issue delay line: stage PU_LATENCY-1 lines up with pu_out.
    // r_dl holds valid&last so it can be counted directly for credit.
    // ------------------------------------------------------------------
    logic [PU_LATENCY-1:0] r_dv;
    logic [PU_LATENCY-1:0] r_dl;
    logic [PU_LATENCY-1:0] w_dv_in;
    logic [PU_LATENCY-1:0] w_dl_in;

    genvar gi;
    generate
        for (gi = 0; gi < PU_LATENCY; gi++) begin : g_delay
            if (gi == 0) begin : g_head
                assign w_dv_in[gi] = issue_valid;
                assign w_dl_in[gi] = issue_valid & issue_last;
            end else begin : g_tail
                assign w_dv_in[gi] = r_dv[gi-1];
                assign w_dl_in[gi] = r_dl[gi-1];
            end
        end
    endgenerate

    // Shift the issue strobes one stage per cycle; reset drops every in-flight group.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv <= '0;
            r_dl <= '0;
        end else begin
            r_dv <= w_dv_in;
            r_dl <= w_dl_in;
        end
    end

    logic w_d_valid;
    logic w_d_last;
    assign w_d_valid = r_dv[PU_LATENCY-1];
    assign w_d_last  = r_dl[PU_LATENCY-1];

    // ------------------------------------------------------------------
    // Accumulator datapath. The sum is one bit wider than the accumulator
    // so a carry out can be detected and clamped instead of wrapping.
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] r_acc;
    logic             r_first;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_pu_ext;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_sum_sat;
    logic [ACC_W-1:0] w_shifted;
    logic [OUT_W-1:0] w_result;

    assign w_base    = r_first ? '0 : r_acc;
    assign w_pu_ext  = {{(ACC_W + 1 - IN_W){1'b0}}, pu_out};
    assign w_sum     = {1'b0, w_base} + w_pu_ext;
    assign w_sum_sat = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_shifted = w_sum_sat >> SHIFT;

    // Output narrowing: clamp when any bit above OUT_W survives the shift.
    generate
        if (OUT_W >= ACC_W) begin : g_out_wide
            assign w_result = OUT_W'(w_shifted);
        end else begin : g_out_narrow
            assign w_result = (|w_shifted[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                          : w_shifted[OUT_W-1:0];
        end
    endgenerate

    // Accumulate each aligned partial sum; a closing group restarts the next output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_first <= 1'b1;
        end else if (w_d_valid) begin
            r_acc   <= w_sum_sat;
            r_first <= w_d_last;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (first-word-fall-through). r_hold remembers the last
    // popped word so res_data stays stable while the FIFO is empty.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] r_hold;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push    = w_d_valid & w_d_last;
    assign w_pop     = ~w_empty & res_ready;
    // A pop on the same edge frees the slot the push needs, even when full.
    assign w_push_ok = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    // Result storage write port; storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push_ok) begin
            r_mem[r_wptr] <= w_result;
        end
    end

    // Pointer, occupancy and hold-register bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_hold  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
                r_hold <= r_mem[r_rptr];
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow: only a push into a full FIFO with no pop loses data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign res_valid = ~w_empty;
    assign res_data  = w_empty ? r_hold : r_mem[r_rptr];
    assign overflow  = r_overflow;

    // ------------------------------------------------------------------
    // Credit: results already queued plus output-closing groups still in
    // the delay line must leave room for one more closing group.
    // ------------------------------------------------------------------
    logic [OUTS_W-1:0] w_outstanding;

    // Count every slot that is, or will become, a FIFO entry.
    always_comb begin
        w_outstanding = OUTS_W'(r_count);
        for (int i = 0; i < PU_LATENCY; i++) begin
            w_outstanding = w_outstanding + OUTS_W'(r_dl[i]);
        end
    end

    assign issue_ready = (w_outstanding < OUTS_W'(FIFO_DEPTH));

endmodule
